// File: rtl/apb_master_nslv.sv
// APB requester: bridges a valid/ready command port to NUM_SLV completers with
// address-window decode, a wait-state timeout and single-cycle response pulses.
module apb_master_nslv #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          NUM_SLV  = 4,
    parameter logic [31:0] SLV_BASE = 32'hA000,
    parameter logic [31:0] SLV_SPAN = 32'h1000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_strb,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int SPAN_LG = $clog2(SLV_SPAN);
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] BASE_X  = (ADDR_W+1)'(SLV_BASE);
    localparam logic [ADDR_W:0] LIMIT_X = BASE_X + (ADDR_W+1)'(NUM_SLV) * (ADDR_W+1)'(SLV_SPAN);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t              state_q, state_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    // Window decode is done one bit wider so the upper limit cannot wrap.
    logic [ADDR_W:0]     addr_x;
    logic [ADDR_W:0]     offset_x;
    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;

    always_comb begin
        addr_x   = {1'b0, cmd_addr};
        offset_x = addr_x - BASE_X;
        dec_hit  = (addr_x >= BASE_X) && (addr_x < LIMIT_X);
        dec_idx  = IDX_W'(offset_x >> SPAN_LG);
    end

    // Only the completer currently selected contributes ready, error and data.
    logic [DATA_W-1:0] slv_rdata [NUM_SLV];
    logic [DATA_W-1:0] sel_rdata;
    logic              sel_ready;
    logic              sel_err;

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign slv_rdata[gi] = psel_q[gi] ? prdata[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_rdata = sel_rdata | slv_rdata[i];
        end
    end

    assign sel_ready = |(pready & psel_q);
    assign sel_err   = |(pslverr & psel_q);

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    if (dec_hit) begin
                        psel_d    = NUM_SLV'(1) << dec_idx;
                        penable_d = 1'b0;
                        state_d   = S_SETUP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                wait_d    = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (sel_ready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    state_d     = S_IDLE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= S_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wait_q      <= wait_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && !preset;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
